// File: rtl/mp_limb_add_seq.sv
// rtl/mp_limb_add_seq.sv - limb-serial multi-precision add/subtract sequencer
//
// Purpose:
//   Feeds two LIMBS x W operands into an external W-bit combinational adder
//   one limb per cycle, LSB limb first. It chains the adder carry-out into the
//   next limb's carry-in and returns the full-width result over valid/ready.
//   Subtraction is A + ~B + ~cin. B is inverted when it is captured, so the
//   adder path is identical for both operations. A final carry of 1 means
//   no borrow.
//
// Optional feature:
//   MPADD_SIGNED_OVF_EN - when defined, res_ovf reports two's-complement
//   overflow of the top limb. When undefined, res_ovf is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready = IDLE)
//   op_a, op_b          W*LIMBS operands
//   op_sub, cin         operation select, carry/borrow-in
//   adder_a/b/ci        limb operands to the external adder (0 outside RUN)
//   adder_s/co          external adder sum and carry-out
//   out_valid/out_ready result handshake
//   res, res_co         W*LIMBS result and final carry (1 = no borrow on sub)
//   res_ovf             signed overflow, valid under out_valid
module mp_limb_add_seq #(
  parameter int LIMBS = 4,
  parameter int W     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*LIMBS-1:0] op_a,
  input  logic [W*LIMBS-1:0] op_b,
  input  logic               op_sub,
  input  logic               cin,
  output logic [W-1:0]       adder_a,
  output logic [W-1:0]       adder_b,
  output logic               adder_ci,
  input  logic [W-1:0]       adder_s,
  input  logic               adder_co,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*LIMBS-1:0] res,
  output logic               res_co,
  output logic               res_ovf
);

  localparam int CW = $clog2(LIMBS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic                      carry_q;
  logic [LIMBS-1:0][W-1:0]   a_q;
  logic [LIMBS-1:0][W-1:0]   b_q;   // already inverted for subtraction
  logic [LIMBS-1:0][W-1:0]   res_q;
  logic                      res_co_q;
  logic                      out_valid_q;

  logic last_limb;
  assign last_limb = (cnt == CW'(LIMBS - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign res_co    = res_co_q;

  // The adder inputs are driven only while limbs are being summed.
  always_comb begin
    adder_a  = '0;
    adder_b  = '0;
    adder_ci = 1'b0;
    if (state == RUN) begin
      adder_a  = a_q[cnt];
      adder_b  = b_q[cnt];
      adder_ci = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_co_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_sub ? ~op_b : op_b;
            // A borrow-in of 1 becomes a carry-in of 0 in A + ~B + c.
            carry_q <= op_sub ? ~cin : cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_q[cnt] <= adder_s;
          carry_q    <= adder_co;
          if (last_limb) begin
            res_co_q <= adder_co;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // out_valid is registered on the first DONE cycle. It drops on
          // the handshake.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MPADD_SIGNED_OVF_EN
  logic res_ovf_q;
  logic sign_a;
  logic sign_b;

  assign sign_a  = a_q[LIMBS-1][W-1];
  assign sign_b  = b_q[LIMBS-1][W-1];
  assign res_ovf = res_ovf_q;

  // Overflow of A + B' + c: the operand signs match and the result sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ovf_q <= 1'b0;
    end else if (state == RUN && last_limb) begin
      res_ovf_q <= (sign_a == sign_b) && (adder_s[W-1] != sign_a);
    end
  end
`else
  assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mp_limb_add_seq.sv
// tb/tb_mp_limb_add_seq.sv - self-checking bench for mp_limb_add_seq
module tb_mp_limb_add_seq;

  localparam int LIMBS = 4;
  localparam int W     = 64;
  localparam int N     = W * LIMBS;

`ifdef MPADD_SIGNED_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] adder_a;
  logic [W-1:0] adder_b;
  logic         adder_ci;
  logic [W-1:0] adder_s;
  logic         adder_co;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res;
  logic         res_co;
  logic         res_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External 64-bit combinational adder
  assign {adder_co, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_ci};

  mp_limb_add_seq #(.LIMBS(LIMBS), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .cin       (cin),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_ci  (adder_ci),
    .adder_s   (adder_s),
    .adder_co  (adder_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_co    (res_co),
    .res_ovf   (res_ovf)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         ci;
    logic [N-1:0] r;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [N+3:0] act, input logic [N+3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: full-width integer add or subtract.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input logic ci, output logic [N-1:0] r, output logic co,
                       output logic ovf);
    logic [N:0] t;
    logic sa, sb, sr;
    if (!sub) t = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
    else      t = {1'b0, a} - {1'b0, b} - (N+1)'(ci);
    r  = t[N-1:0];
    co = sub ? ~t[N] : t[N];
    sa = a[N-1];
    sb = b[N-1];
    sr = r[N-1];
    ovf = OVF_ON && (sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa));
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                      input logic ci);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    op_a = a; op_b = b; op_sub = sub; cin = ci; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      failures++;
      $display("FAIL out_valid_timeout actual=0 required=1");
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic sub, input logic ci, input logic [N-1:0] er,
                           input logic eco, input logic eovf, input bit chk_lat);
    int lat;
    send(a, b, sub, ci);
    wait_valid(lat);
    if (chk_lat) chk({nm, "_latency"}, lat, LIMBS + 1);
    chk({nm, "_res"}, res, er);
    chk({nm, "_co"}, res_co, eco);
    chk({nm, "_ovf"}, res_ovf, eovf);
    release_out();
  endtask

  initial begin
    logic [N-1:0] ra, rb, er, saved;
    logic         rs, rc, eco, eovf;
    int           lat;

    tbl[0] = '{a: (256'h1 << 64) - 256'h1, b: 256'h1, sub: 1'b0, ci: 1'b0,
               r: 256'h1 << 64, co: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: {N{1'b1}}, b: '0, sub: 1'b0, ci: 1'b1,
               r: '0, co: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 256'h5, b: 256'h7, sub: 1'b1, ci: 1'b0,
               r: {{(N-1){1'b1}}, 1'b0}, co: 1'b0, ovf: 1'b0};
    tbl[3] = '{a: 256'h7, b: 256'h5, sub: 1'b1, ci: 1'b0,
               r: 256'h2, co: 1'b1, ovf: 1'b0};
    tbl[4] = '{a: {1'b0, {(N-1){1'b1}}}, b: 256'h1, sub: 1'b0, ci: 1'b0,
               r: 256'h1 << 255, co: 1'b0, ovf: 1'b1};
    tbl[5] = '{a: 256'h1 << 255, b: 256'h1, sub: 1'b1, ci: 1'b0,
               r: {1'b0, {(N-1){1'b1}}}, co: 1'b1, ovf: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = {N{1'b1}}; op_b = {N{1'b1}}; op_sub = 1'b0; cin = 1'b1;
    #2;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_res", res, '0);
    chk("reset_res_co", res_co, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_adder_a_zero", adder_a, '0);
    chk("idle_adder_ci_zero", adder_ci, 1'b0);

    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].ci,
                tbl[i].r, tbl[i].co, tbl[i].ovf & OVF_ON, 1'b1);

    // Hold the result under backpressure while a new request is offered.
    send(256'h7, 256'h5, 1'b1, 1'b0);
    wait_valid(lat);
    saved = res;
    chk("bp_res_first", res, 256'h2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_a = 256'h1234; op_b = 256'h1; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_res_stable", res, saved);
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_released_out_valid", out_valid, 1'b0);
    chk("bp_released_in_ready", in_ready, 1'b1);
    run_check("bp_next", 256'h1234, 256'h1, 1'b0, 1'b0, 256'h1235, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of RUN.
    send({N{1'b1}}, 256'h0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_res", res, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_adder_a", adder_a, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("midrst_fresh", tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0].ci,
              tbl[0].r, tbl[0].co, 1'b0, 1'b1);

    // Randomized operands against the arithmetic model.
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < N / 32; k++) begin
        ra[k*32 +: 32] = $urandom();
        rb[k*32 +: 32] = $urandom();
      end
      // Sometimes force long carry/borrow chains.
      case ($urandom_range(0, 3))
        0: ra = {N{1'b1}};
        1: rb = '0;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rc, er, eco, eovf);
      run_check($sformatf("rand%0d", n), ra, rb, rs, rc, er, eco, eovf, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
